// File: rtl/mem_to_uart_tx.sv
// mem_to_uart_tx: reads the finished result matrix entry by entry and
// streams each entry MSB byte first on a UART 8N1 line paced by baud_tick.
//
// Ports:
//   clk            system clock, all logic on posedge
//   rst            synchronous active-high reset
//   start          level request to send the whole matrix (seen in IDLE)
//   baud_tick      one-clk pulse per bit period
//   read_R         result-memory read enable (high only in FETCH)
//   read_address_R result-memory read address (holds last value)
//   data_R         result-memory read data, valid the clk after read_R
//   tx_data        serial line, idle high
//   busy           high in FETCH, LATCH, LOAD and SEND
//   sent_completed high while in DONE
module mem_to_uart_tx #(
  parameter int row          = 2,
  parameter int column       = 2,
  parameter int total_values = row * column,
  parameter int RESULT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                baud_tick,
  output logic                read_R,
  output logic [31:0]         read_address_R,
  input  logic [RESULT_W-1:0] data_R,
  output logic                tx_data,
  output logic                busy,
  output logic                sent_completed
);

  localparam int NBYTES = (RESULT_W + 7) / 8;
  localparam int WW     = NBYTES * 8;

  localparam logic [31:0] LAST_IDX  = 32'(total_values - 1);
  localparam logic [1:0]  LAST_BYTE = 2'(NBYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    LOAD,
    SEND,
    DONE
  } state_e;

  state_e        state_q;
  logic [31:0]   idx_q;
  logic [1:0]    byte_q;
  logic [WW-1:0] word_q;
  logic [7:0]    sh_q;
  logic [3:0]    bit_q;
  logic          read_q;
  logic          tx_q;
  logic          busy_q;
  logic          done_q;

  // Next-state helpers for the end-of-frame decision.
  logic [WW-1:0] word_d;
  logic [31:0]   idx_d;
  logic [1:0]    byte_d;
  logic          more_bytes_d;
  logic          more_vals_d;

  always_comb begin
    word_d       = word_q << 8;
    idx_d        = idx_q + 32'd1;
    byte_d       = byte_q - 2'd1;
    more_bytes_d = (byte_q != 2'd0);
    more_vals_d  = (idx_q != LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      read_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= FETCH;
            idx_q   <= '0;
            read_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end

        FETCH: begin
          read_q  <= 1'b0;
          state_q <= LATCH;
        end

        LATCH: begin
          // Zero-extend so the top byte is padded when RESULT_W
          // is not a whole number of bytes.
          word_q  <= WW'(data_R);
          byte_q  <= LAST_BYTE;
          state_q <= LOAD;
        end

        LOAD: begin
          if (baud_tick) begin
            sh_q    <= word_q[WW-1 -: 8];
            tx_q    <= 1'b0;
            bit_q   <= '0;
            state_q <= SEND;
          end
        end

        SEND: begin
          if (baud_tick) begin
            if (bit_q < 4'd8) begin
              tx_q  <= sh_q[0];
              sh_q  <= sh_q >> 1;
              bit_q <= bit_q + 4'd1;
            end else if (bit_q == 4'd8) begin
              tx_q  <= 1'b1;
              bit_q <= 4'd9;
            end else begin
              // Stop bit period is over; line stays high.
              if (more_bytes_d) begin
                byte_q  <= byte_d;
                word_q  <= word_d;
                state_q <= LOAD;
              end else if (more_vals_d) begin
                idx_q   <= idx_d;
                read_q  <= 1'b1;
                state_q <= FETCH;
              end else begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= DONE;
              end
            end
          end
        end

        DONE: begin
          if (!start) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
          read_q  <= 1'b0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign read_R         = read_q;
  assign read_address_R = idx_q;
  assign tx_data        = tx_q;
  assign busy           = busy_q;
  assign sent_completed = done_q;

endmodule

// File: doc/mem_to_uart_tx.md
Name: mem_to_uart_tx

Overview:
- Downstream output stage of the matrix multiplier.
- Once the result matrix is complete in result memory, it reads every entry in address order, splits each entry into bytes (MSB byte first), and serialises them on a UART 8N1 line.
- It is the transmit counterpart of the UART receive-to-memory loader.
- It drives the memory read port directly and paces bits from a one-cycle baud tick enable in the system clock domain.

Parameters:
row, 2, rows of result matrix
column, 2, columns of result matrix
total_values, row*column, number of entries sent
RESULT_W, 16, width of one result entry in bits (1..32)
NBYTES, ceil(RESULT_W/8), bytes per entry (derived, not overridable)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous active-high reset
start  input  1  level request to send the whole matrix; sampled only in IDLE
baud_tick  input  1  one-clk-wide pulse, one per bit period
read_R  output  1  result-memory read enable
read_address_R  output  32  result-memory read address
data_R  input  RESULT_W  result-memory read data, valid the clk after read_R
tx_data  output  1  serial line, idle high
busy  output  1  high from leaving IDLE until entering DONE
sent_completed  output  1  high while in DONE

Behaviour:
- Reset values: tx_data=1, read_R=0, read_address_R=0, busy=0, sent_completed=0; state IDLE; value index=0; byte index=0.
- Reset mid-frame takes effect at that edge: tx_data=1 next cycle and the frame is truncated. No resume.
- State machine:
  - IDLE: if start=1, go to FETCH and set index=0.
  - FETCH (1 clk): read_R=1, read_address_R=index; go to LATCH.
  - LATCH (1 clk): capture data_R into a shift word zero-extended to NBYTES*8; byte index=NBYTES-1; go to LOAD.
  - LOAD: select byte[byte index]; wait for baud_tick. On that tick drive start bit 0 and go to SEND.
  - SEND: on each subsequent baud_tick drive data bits LSB first (8 ticks), then the stop bit 1 (1 tick). On the tick after the stop bit, the line returns to idle high.
  - After the stop bit, if byte index>0: decrement it and go to LOAD.
  - Else if index<total_values-1: increment index and go to FETCH.
  - Else go to DONE.
  - DONE: sent_completed=1. Go to IDLE when start=0; hold while start=1.
- read_R is high only in FETCH. Otherwise read_R=0 and read_address_R holds its last value.
- tx_data changes only on a clk edge where baud_tick=1, except on reset.
- Frame timing:
  - A start bit lasts exactly one tick period.
  - Minimum high between consecutive frames is one tick period: the stop bit ends, then LOAD waits for the next tick. It may be longer between entries.
  - Frames are never shortened or stretched mid-frame.
- baud_tick arriving during FETCH or LATCH is ignored; it is not queued.
- start is ignored in all states other than IDLE and DONE. Deasserting start mid-transfer has no effect.
- Byte order: byte NBYTES-1 (most significant, zero-padded when RESULT_W is not a multiple of 8) first, byte 0 last.
- Index counter is 32 bits wide; it never wraps for legal total_values.
- busy=1 in FETCH, LATCH, LOAD and SEND.

Test Plan:
- rst=1 for 3 clks with start=1 and baud_tick every 4 clks -> tx_data=1, read_R=0, busy=0, sent_completed=0 throughout.
- Memory {0x1234,0x00FF,0xA5A5,0x0001}, RESULT_W=16, start held high, baud_tick every 4 clks:
  - decoded stream is 12 34 00 FF A5 A5 00 01;
  - each frame is 10 tick periods with start bit 0 and stop bit 1;
  - read_R pulses exactly 4 times with addresses 0,1,2,3, each pulse one clk wide;
  - sent_completed rises after the last stop bit and holds; dropping start returns to IDLE next clk.
- RESULT_W=12, entry 0xABC -> bytes 0x0A then 0xBC.
- Single byte 0x5A: line samples at tick periods are 0,0,1,0,1,1,0,1,0,1, then idle 1 for at least one period before the next start bit.
- rst asserted during the 4th data bit of the 2nd byte -> tx_data=1 next clk and state IDLE. Re-asserting start restarts from address 0 with the first byte 0x12.
- start pulsed low/high during SEND -> no change to the stream; start held high in DONE -> stays in DONE with no new read_R.
